// File: rtl/eightgate_collector.sv
// 8-to-1 event collector: sticky pending bits, arbitration, valid/ready select offer.
// Build option RR_ARB_EN: round-robin winner selection instead of fixed lowest-index priority.
module eightgate_collector #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic [7:0]       pending,
    output logic             ovf,
    output logic [CNT_W-1:0] gnt_cnt
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_sel;
    logic             r_valid;
    logic [7:0]       r_pend;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hs;
    logic             w_any;
    logic [7:0]       w_clr;
    logic [2:0]       w_win;

    assign w_hs  = (r_state == OFFER) && r_valid && out_ready;
    assign w_clr = w_hs ? (8'b1 << r_sel) : 8'b0;
    assign w_any = |r_pend;

`ifdef RR_ARB_EN
    logic [2:0] r_rr_ptr;

    // Walk the offsets from farthest to nearest so the first set bit after rr_ptr wins.
    always_comb begin
        w_win = '0;
        for (int k = 8; k >= 1; k--) begin
            if (r_pend[r_rr_ptr + 3'(k)])
                w_win = r_rr_ptr + 3'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rr_ptr <= 3'd7;
        else if (w_hs)
            r_rr_ptr <= r_sel;
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = 7; k >= 0; k--) begin
            if (r_pend[k])
                w_win = 3'(k);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = OFFER;
            OFFER:   if (w_hs)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // A new event in the handshake cycle survives the clear.
            r_pend <= (r_pend & ~w_clr) | req;
            r_ovf  <= |(req & r_pend & ~w_clr);
            if (r_state == IDLE && w_any) begin
                r_sel   <= w_win;
                r_valid <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign s0        = r_sel[2];
    assign s1        = r_sel[1];
    assign s2        = r_sel[0];
    assign pending   = r_pend;
    assign ovf       = r_ovf;
    assign gnt_cnt   = r_cnt;

endmodule
